// File: rtl/rails_dispatcher.sv
// rails_dispatcher: buffers a rails frame (car count N, then N departure-order
// car numbers) and replays it to the stack yard as a handshaked push/pop
// command stream, ending each frame with a one-cycle done/result pulse.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   data      in   [3:0] frame input (0 = idle/abort, header N, then N entries)
//   busy      out  high while dispatching (RUN) and during the done cycle
//   op_valid  out  yard command presented
//   op_ready  in   yard accepts command (transfer on op_valid && op_ready)
//   op_push   out  1 = push arriving car, 0 = pop top car to departure track
//   op_car    out  [3:0] car moved by the presented command
//   done      out  one-cycle frame-end pulse
//   result    out  feasibility result, valid while done = 1
module rails_dispatcher #(
    parameter int unsigned MAX_CARS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data,
    output logic       busy,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       op_push,
    output logic [3:0] op_car,
    output logic       done,
    output logic       result
);

    localparam int unsigned IW    = $clog2(MAX_CARS + 1);
    localparam int unsigned DEPTH = 1 << IW;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_d;
    logic [3:0]    n, n_d;
    logic [3:0]    next_in, next_in_d;
    logic [IW-1:0] idx, idx_d;
    logic [IW-1:0] out_idx, out_idx_d;
    logic [IW-1:0] sp, sp_d;
    logic          bad, bad_d;
    logic [15:0]   seen, seen_d;

    logic [3:0]    order [DEPTH];
    logic [3:0]    stack [DEPTH];

    logic          ord_we, stk_we, fire, res_d;
    logic [IW-1:0] idx_inc, out_inc;
    logic [3:0]    target_d, top_d;
    logic          busy_d, valid_d, push_d, done_d, result_d;
    logic [3:0]    car_d;

    // Next-state logic, followed by a lookahead of the command the yard sees
    // next cycle so the outputs come straight from registers.
    always_comb begin
        state_d   = state;
        n_d       = n;
        next_in_d = next_in;
        idx_d     = idx;
        out_idx_d = out_idx;
        sp_d      = sp;
        bad_d     = bad;
        seen_d    = seen;
        ord_we    = 1'b0;
        stk_we    = 1'b0;
        res_d     = 1'b0;
        fire      = op_valid && op_ready;
        idx_inc   = idx + IW'(1);
        out_inc   = out_idx + IW'(1);

        case (state)
            IDLE: begin
                if (data != 4'd0 && 32'(data) <= MAX_CARS) begin
                    n_d     = data;
                    bad_d   = 1'b0;
                    idx_d   = '0;
                    seen_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (data == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    ord_we = 1'b1;
                    idx_d  = idx_inc;
                    seen_d = seen | (16'(1) << data);
                    if (data > n || seen[data]) begin
                        bad_d = 1'b1;
                    end
                    if (idx_inc == IW'(n)) begin
                        if (bad_d) begin
                            state_d = DONE;
                        end else begin
                            state_d   = RUN;
                            next_in_d = 4'd1;
                            out_idx_d = '0;
                            sp_d      = '0;
                        end
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    if (op_push) begin
                        stk_we    = 1'b1;
                        sp_d      = sp + IW'(1);
                        next_in_d = next_in + 4'd1;
                    end else begin
                        sp_d      = sp - IW'(1);
                        out_idx_d = out_inc;
                        if (out_inc == IW'(n)) begin
                            state_d = DONE;
                            res_d   = 1'b1;
                        end
                    end
                end else if (!op_valid) begin
                    // No legal move exists for the current target.
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Target and stack top as they will be after this edge.
        target_d = (ord_we && idx == out_idx_d) ? data : order[out_idx_d];
        top_d    = stk_we ? op_car : stack[sp_d - IW'(1)];

        valid_d = 1'b0;
        push_d  = 1'b0;
        car_d   = 4'd0;
        if (state_d == RUN) begin
            if (sp_d != '0 && top_d == target_d) begin
                valid_d = 1'b1;
                car_d   = target_d;
            end else if (next_in_d <= target_d) begin
                valid_d = 1'b1;
                push_d  = 1'b1;
                car_d   = next_in_d;
            end
        end

        busy_d   = (state_d == RUN) || (state_d == DONE);
        done_d   = (state_d == DONE);
        result_d = done_d && res_d;
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            n        <= 4'd0;
            next_in  <= 4'd0;
            idx      <= '0;
            out_idx  <= '0;
            sp       <= '0;
            bad      <= 1'b0;
            seen     <= '0;
            busy     <= 1'b0;
            op_valid <= 1'b0;
            op_push  <= 1'b0;
            op_car   <= 4'd0;
            done     <= 1'b0;
            result   <= 1'b0;
        end else begin
            state    <= state_d;
            n        <= n_d;
            next_in  <= next_in_d;
            idx      <= idx_d;
            out_idx  <= out_idx_d;
            sp       <= sp_d;
            bad      <= bad_d;
            seen     <= seen_d;
            busy     <= busy_d;
            op_valid <= valid_d;
            op_push  <= push_d;
            op_car   <= car_d;
            done     <= done_d;
            result   <= result_d;
        end
    end

    // Order buffer and yard stack storage; contents are only read when valid.
    always_ff @(posedge clk) begin
        if (ord_we) begin
            order[idx] <= data;
        end
        if (stk_we) begin
            stack[sp] <= op_car;
        end
    end

endmodule

// File: tb/tb_rails_dispatcher.sv
module tb_rails_dispatcher;

    localparam int unsigned MAX_CARS = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] data = 4'd0;
    logic       op_ready = 1'b0;
    logic       busy, op_valid, op_push, done, result;
    logic [3:0] op_car;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit push;
        int car;
    } op_t;

    op_t exp_ops[$];
    bit  exp_feasible;

    rails_dispatcher #(.MAX_CARS(MAX_CARS)) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .busy     (busy),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_push  (op_push),
        .op_car   (op_car),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: yard moves derived directly from the departure order.
    function automatic void model(input int ord[$]);
        int  stk[$];
        int  nxt;
        bit  stuck;
        op_t o;
        exp_ops.delete();
        nxt = 1;
        exp_feasible = 1'b1;
        foreach (ord[i]) begin
            stuck = 1'b0;
            while (!stuck && !(stk.size() > 0 && stk[$] == ord[i])) begin
                if (nxt <= ord[i]) begin
                    o.push = 1'b1;
                    o.car  = nxt;
                    exp_ops.push_back(o);
                    stk.push_back(nxt);
                    nxt++;
                end else begin
                    stuck = 1'b1;
                end
            end
            if (stuck) begin
                exp_feasible = 1'b0;
                break;
            end
            o.push = 1'b0;
            o.car  = ord[i];
            exp_ops.push_back(o);
            void'(stk.pop_back());
        end
    endfunction

    function automatic bit is_bad(input int ord[$]);
        bit s[16];
        foreach (s[i]) s[i] = 1'b0;
        foreach (ord[i]) begin
            if (ord[i] > ord.size() || s[ord[i]]) return 1'b1;
            s[ord[i]] = 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".op_valid"}, op_valid, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    // Drives one frame starting at a negedge with the DUT idle; samples and
    // drives on negedges and checks every cycle against the model.
    task automatic run_frame(input int ord[$], input int abort_at, input int stall_pct,
                             input int stall_op, input int stall_len);
        int  n;
        int  k;
        int  stalled;
        int  cyc;
        bit  dead;
        bit  rdy;
        op_t pend[$];
        op_t o;
        n = ord.size();
        chk_quiet("hdr");
        data = 4'(n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk_quiet("load");
            data = (i == abort_at) ? 4'd0 : 4'(ord[i]);
            @(negedge clk);
            if (i == abort_at) begin
                data = 4'd0;
                for (int j = 0; j < 3; j++) begin
                    chk_quiet("abort");
                    @(negedge clk);
                end
                return;
            end
        end
        if (is_bad(ord)) begin
            chk("bad.done", done, 1);
            chk("bad.result", result, 0);
            chk("bad.busy", busy, 1);
            chk("bad.op_valid", op_valid, 0);
            data = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk_quiet("bad.after");
            data = 4'd0;
            return;
        end
        model(ord);
        pend = exp_ops;
        k = 0;
        stalled = 0;
        dead = 1'b0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (pend.size() > 0) begin
                o = pend[0];
                chk("run.op_valid", op_valid, 1);
                chk("run.op_push", op_push, int'(o.push));
                chk("run.op_car", op_car, o.car);
                chk("run.done", done, 0);
                chk("run.busy", busy, 1);
                if (k == stall_op && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(0, 99) >= stall_pct);
                end
                op_ready = rdy;
                if (rdy) begin
                    void'(pend.pop_front());
                    k++;
                end
            end else if (exp_feasible || dead) begin
                chk("end.done", done, 1);
                chk("end.result", result, int'(exp_feasible));
                chk("end.op_valid", op_valid, 0);
                chk("end.busy", busy, 1);
                op_ready = 1'($urandom_range(0, 1));
                data = 4'($urandom_range(0, 15));
                @(negedge clk);
                chk_quiet("end.after");
                data = 4'd0;
                op_ready = 1'b0;
                return;
            end else begin
                chk("dead.op_valid", op_valid, 0);
                chk("dead.done", done, 0);
                chk("dead.busy", busy, 1);
                op_ready = 1'($urandom_range(0, 1));
                dead = 1'b1;
            end
            data = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        chk("run.timeout", 0, 1);
        data = 4'd0;
    endtask

    initial begin
        int q[$];
        int n;
        int t;
        int r;

        // Pin the model on hand-worked orders.
        q = {3, 1, 2};
        model(q);
        chk("model.312.feasible", 32'(exp_feasible), 0);
        chk("model.312.nops", exp_ops.size(), 4);
        chk("model.312.last", exp_ops[3].push ? exp_ops[3].car + 100 : exp_ops[3].car, 3);
        q = {5, 4, 3, 2, 1};
        model(q);
        chk("model.54321.nops", exp_ops.size(), 10);
        chk("model.54321.op4", exp_ops[4].push ? exp_ops[4].car + 100 : exp_ops[4].car, 105);
        chk("model.54321.op5", exp_ops[5].push ? exp_ops[5].car + 100 : exp_ops[5].car, 5);
        q = {2, 1, 4, 3};
        model(q);
        chk("model.2143.op1", exp_ops[1].push ? exp_ops[1].car + 100 : exp_ops[1].car, 102);
        chk("model.2143.feasible", 32'(exp_feasible), 1);
        q = {2, 2, 1};
        chk("model.221.bad", 32'(is_bad(q)), 1);

        // Reset state.
        #1 reset = 1'b1;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.op_valid", op_valid, 0);
        chk("rst.op_push", op_push, 0);
        chk("rst.op_car", op_car, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed frames.
        q = {1, 2, 3, 4, 5};  run_frame(q, -1, 0, -1, 0);
        q = {5, 4, 3, 2, 1};  run_frame(q, -1, 0, -1, 0);
        q = {3, 1, 2};        run_frame(q, -1, 0, -1, 0);
        q = {2, 1, 4, 3};     run_frame(q, -1, 0, 1, 5);
        q = {2, 2, 1};        run_frame(q, -1, 0, -1, 0);
        q = {1, 2, 3, 4};     run_frame(q, 2, 0, -1, 0);
        q = {4, 3, 1, 2};     run_frame(q, -1, 0, -1, 0);

        // Out-of-range header is ignored.
        data = 4'd12;
        @(negedge clk);
        chk_quiet("hdr12");
        q = {1};              run_frame(q, -1, 0, -1, 0);

        // Reset in the middle of RUN.
        data = 4'd5;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            data = 4'(i);
            @(negedge clk);
        end
        data = 4'd0;
        op_ready = 1'b1;
        chk("mid.op_car0", op_car, 1);
        @(negedge clk);
        chk("mid.op_push1", op_push, 0);
        #3 reset = 1'b1;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.op_valid", op_valid, 0);
        chk("mid.op_push", op_push, 0);
        chk("mid.op_car", op_car, 0);
        chk("mid.done", done, 0);
        chk("mid.result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        op_ready = 1'b0;
        q = {2, 1};           run_frame(q, -1, 0, -1, 0);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            n = $urandom_range(1, MAX_CARS);
            q.delete();
            for (int i = 1; i <= n; i++) q.push_back(i);
            for (int i = n - 1; i > 0; i--) begin
                int j;
                j = $urandom_range(0, i);
                t = q[i];
                q[i] = q[j];
                q[j] = t;
            end
            r = $urandom_range(0, 9);
            if (r == 0) q[$urandom_range(0, n - 1)] = $urandom_range(1, 12);
            if ($urandom_range(0, 5) == 0) begin
                data = 4'($urandom_range(11, 15));
                @(negedge clk);
                chk_quiet("rnd.hdr");
            end
            run_frame(q, (r == 1) ? int'($urandom_range(0, n - 1)) : -1, 35, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
